// File: rtl/mat_store_pkg.sv
// rtl/mat_store_pkg.sv - shared defaults, FSM encodings and address helper for the matrix store
package mat_store_pkg;

    localparam int MAT_DIM_WIDTH  = 3;
    localparam int MAT_DATA_WIDTH = 8;
    localparam int MAT_SLOT_WIDTH = 1;
    localparam int MAT_MAX_DIM    = 5;
    localparam int MAT_RD_LATENCY = 1;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_FILL   = 2'd1,
        W_COMMIT = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_GAP  = 2'd2
    } r_state_e;

    function automatic int mat_addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mat_store_if.sv
// rtl/mat_store_if.sv - write stream, read port and slot metadata bundle for the matrix store
interface mat_store_if
    import mat_store_pkg::*;
#(
    parameter int SLOT_WIDTH = MAT_SLOT_WIDTH,
    parameter int DIM_WIDTH  = MAT_DIM_WIDTH,
    parameter int DATA_WIDTH = MAT_DATA_WIDTH
);
    localparam int NUM_SLOTS = 2**SLOT_WIDTH;

    logic                           wr_start;
    logic [SLOT_WIDTH-1:0]          wr_slot_idx;
    logic [DIM_WIDTH-1:0]           wr_m;
    logic [DIM_WIDTH-1:0]           wr_n;
    logic                           wr_valid;
    logic [DATA_WIDTH-1:0]          wr_elem;
    logic                           wr_ready;
    logic                           wr_busy;
    logic                           wr_done;
    logic                           wr_err;
    logic                           rd_en;
    logic [SLOT_WIDTH-1:0]          rd_slot_idx;
    logic [DIM_WIDTH-1:0]           rd_row_idx;
    logic [DIM_WIDTH-1:0]           rd_col_idx;
    logic [DATA_WIDTH-1:0]          rd_elem;
    logic                           rd_elem_valid;
    logic                           rd_err;
    logic [NUM_SLOTS-1:0]           slot_valid;
    logic [NUM_SLOTS*DIM_WIDTH-1:0] slot_m_flat;
    logic [NUM_SLOTS*DIM_WIDTH-1:0] slot_n_flat;

    modport master (
        output wr_start, wr_slot_idx, wr_m, wr_n, wr_valid, wr_elem,
        output rd_en, rd_slot_idx, rd_row_idx, rd_col_idx,
        input  wr_ready, wr_busy, wr_done, wr_err,
        input  rd_elem, rd_elem_valid, rd_err,
        input  slot_valid, slot_m_flat, slot_n_flat
    );

    modport slave (
        input  wr_start, wr_slot_idx, wr_m, wr_n, wr_valid, wr_elem,
        input  rd_en, rd_slot_idx, rd_row_idx, rd_col_idx,
        output wr_ready, wr_busy, wr_done, wr_err,
        output rd_elem, rd_elem_valid, rd_err,
        output slot_valid, slot_m_flat, slot_n_flat
    );

endinterface

// File: rtl/mat_store_mem.sv
// rtl/mat_store_mem.sv - element array with one synchronous write port and one registered read port
module mat_store_mem #(
    parameter int DEPTH      = 50,
    parameter int AW         = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic                  rzero_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // rzero_i squashes the data of a rejected request so it never leaks stale contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mat_store.sv
// rtl/mat_store.sv - matrix store: row-major load FSM, latency-timed read responder, slot metadata
module mat_store
    import mat_store_pkg::*;
#(
    parameter int DIM_WIDTH  = MAT_DIM_WIDTH,
    parameter int DATA_WIDTH = MAT_DATA_WIDTH,
    parameter int SLOT_WIDTH = MAT_SLOT_WIDTH,
    parameter int MAX_DIM    = MAT_MAX_DIM,
    parameter int RD_LATENCY = MAT_RD_LATENCY
) (
    input  logic       clk,
    input  logic       rst_n,
    mat_store_if.slave bus
);

    localparam int NUM_SLOTS = 2**SLOT_WIDTH;
    localparam int DEPTH     = NUM_SLOTS * MAX_DIM * MAX_DIM;
    localparam int AW        = mat_addr_width(DEPTH);
    localparam int LW        = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);

    function automatic logic [AW-1:0] elem_addr(input logic [SLOT_WIDTH-1:0] s,
                                                 input logic [DIM_WIDTH-1:0]  r,
                                                 input logic [DIM_WIDTH-1:0]  c);
        return AW'(s) * AW'(MAX_DIM * MAX_DIM) + AW'(r) * AW'(MAX_DIM) + AW'(c);
    endfunction

    w_state_e                            w_state_q;
    logic [SLOT_WIDTH-1:0]               w_slot_q;
    logic [DIM_WIDTH-1:0]                w_m_q, w_n_q, w_row_q, w_col_q;
    logic                                wr_done_q, wr_err_q;
    logic [NUM_SLOTS-1:0]                slot_valid_q;
    logic [NUM_SLOTS-1:0][DIM_WIDTH-1:0] slot_m_q, slot_n_q;

    r_state_e                            r_state_q;
    logic [LW-1:0]                       r_cnt_q;
    logic                                r_err_q, rd_valid_q, rd_err_q;
    logic                                rd_accept, rd_req_err, rd_valid_d, rd_err_d;

    logic                                dims_ok, mem_we;
    logic [AW-1:0]                       mem_waddr, mem_raddr;
    logic [DATA_WIDTH-1:0]               mem_rdata;

    assign dims_ok = (bus.wr_m != '0) && (bus.wr_m <= DIM_WIDTH'(MAX_DIM)) &&
                     (bus.wr_n != '0) && (bus.wr_n <= DIM_WIDTH'(MAX_DIM));
    assign mem_we    = (w_state_q == W_FILL) && bus.wr_valid;
    assign mem_waddr = elem_addr(w_slot_q, w_row_q, w_col_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q    <= W_IDLE;
            w_slot_q     <= '0;
            w_m_q        <= '0;
            w_n_q        <= '0;
            w_row_q      <= '0;
            w_col_q      <= '0;
            wr_done_q    <= 1'b0;
            wr_err_q     <= 1'b0;
            slot_valid_q <= '0;
            slot_m_q     <= '0;
            slot_n_q     <= '0;
        end else begin
            wr_done_q <= 1'b0;
            wr_err_q  <= 1'b0;
            case (w_state_q)
                W_IDLE: begin
                    if (bus.wr_start) begin
                        if (dims_ok) begin
                            w_slot_q                       <= bus.wr_slot_idx;
                            w_m_q                          <= bus.wr_m;
                            w_n_q                          <= bus.wr_n;
                            w_row_q                        <= '0;
                            w_col_q                        <= '0;
                            slot_valid_q[bus.wr_slot_idx]  <= 1'b0;
                            w_state_q                      <= W_FILL;
                        end else begin
                            wr_err_q <= 1'b1;
                        end
                    end
                end
                W_FILL: begin
                    if (bus.wr_valid) begin
                        if (w_col_q == w_n_q - DIM_WIDTH'(1)) begin
                            w_col_q <= '0;
                            if (w_row_q == w_m_q - DIM_WIDTH'(1)) begin
                                w_state_q <= W_COMMIT;
                            end else begin
                                w_row_q <= w_row_q + DIM_WIDTH'(1);
                            end
                        end else begin
                            w_col_q <= w_col_q + DIM_WIDTH'(1);
                        end
                    end
                end
                W_COMMIT: begin
                    slot_valid_q[w_slot_q] <= 1'b1;
                    slot_m_q[w_slot_q]     <= w_m_q;
                    slot_n_q[w_slot_q]     <= w_n_q;
                    wr_done_q              <= 1'b1;
                    w_state_q              <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Validity is judged on registered metadata, so a read racing a load start sees the old slot
    assign rd_accept  = (r_state_q == R_IDLE) && bus.rd_en;
    assign rd_req_err = !slot_valid_q[bus.rd_slot_idx] ||
                        (bus.rd_row_idx >= slot_m_q[bus.rd_slot_idx]) ||
                        (bus.rd_col_idx >= slot_n_q[bus.rd_slot_idx]);
    assign mem_raddr  = rd_req_err ? '0 : elem_addr(bus.rd_slot_idx, bus.rd_row_idx, bus.rd_col_idx);

    always_comb begin
        rd_valid_d = 1'b0;
        case (r_state_q)
            R_IDLE:  rd_valid_d = rd_accept && (RD_LATENCY == 1);
            R_WAIT:  rd_valid_d = (r_cnt_q != LW'(RD_LATENCY)) &&
                                  (r_cnt_q + LW'(1) == LW'(RD_LATENCY));
            default: rd_valid_d = 1'b0;
        endcase
        rd_err_d = rd_valid_d && ((r_state_q == R_IDLE) ? rd_req_err : r_err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q  <= R_IDLE;
            r_cnt_q    <= '0;
            r_err_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            case (r_state_q)
                R_IDLE: begin
                    if (rd_accept) begin
                        r_err_q   <= rd_req_err;
                        r_cnt_q   <= LW'(1);
                        r_state_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_cnt_q == LW'(RD_LATENCY)) begin
                        r_state_q <= R_GAP;
                    end else begin
                        r_cnt_q <= r_cnt_q + LW'(1);
                    end
                end
                R_GAP:   r_state_q <= R_IDLE;
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    mat_store_mem #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (bus.wr_elem),
        .re_i    (rd_accept),
        .rzero_i (rd_req_err),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    // With longer latency the array output changes at acceptance, so hold the previous response
    if (RD_LATENCY == 1) begin : g_rd_direct
        assign bus.rd_elem = mem_rdata;
    end else begin : g_rd_hold
        logic [DATA_WIDTH-1:0] rd_elem_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_elem_q <= '0;
            end else if (rd_valid_d) begin
                rd_elem_q <= mem_rdata;
            end
        end
        assign bus.rd_elem = rd_elem_q;
    end

    assign bus.wr_ready      = (w_state_q == W_IDLE);
    assign bus.wr_busy       = (w_state_q != W_IDLE);
    assign bus.wr_done       = wr_done_q;
    assign bus.wr_err        = wr_err_q;
    assign bus.rd_elem_valid = rd_valid_q;
    assign bus.rd_err        = rd_err_q;
    assign bus.slot_valid    = slot_valid_q;
    assign bus.slot_m_flat   = slot_m_q;
    assign bus.slot_n_flat   = slot_n_q;

endmodule

// File: tb/tb_mat_store.sv
// tb/tb_mat_store.sv - directed self-checking bench for mat_store
module tb_mat_store;
    import mat_store_pkg::*;

    localparam int SW = 1;
    localparam int DW = 3;
    localparam int XW = 8;
    localparam int MD = 5;
    localparam int RL = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mat_store_if #(.SLOT_WIDTH(SW), .DIM_WIDTH(DW), .DATA_WIDTH(XW)) bus();

    mat_store #(
        .DIM_WIDTH(DW), .DATA_WIDTH(XW), .SLOT_WIDTH(SW), .MAX_DIM(MD), .RD_LATENCY(RL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_begin(input int s, input int m, input int n);
        bus.wr_start    = 1'b1;
        bus.wr_slot_idx = SW'(s);
        bus.wr_m        = DW'(m);
        bus.wr_n        = DW'(n);
        tick();
        bus.wr_start = 1'b0;
        checks++;
        if (bus.wr_busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_begin_busy slot%0d got %0b want 1", s, bus.wr_busy);
        end
    endtask

    task automatic wr_push(input int base, input int step, input int count);
        for (int i = 0; i < count; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_elem  = XW'(base + i * step);
            tick();
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic wr_finish(input int s, input int m, input int n);
        logic [DW-1:0] gm, gn;
        tick();
        gm = bus.slot_m_flat[s*DW +: DW];
        gn = bus.slot_n_flat[s*DW +: DW];
        checks++;
        if (bus.wr_done !== 1'b1 || bus.slot_valid[s] !== 1'b1 || gm !== DW'(m) || gn !== DW'(n)) begin
            errors++;
            $display("FAIL wr_commit slot%0d got done=%0b valid=%0b m=%0d n=%0d want 1 1 %0d %0d",
                     s, bus.wr_done, bus.slot_valid[s], gm, gn, m, n);
        end
        tick();
        checks++;
        if (bus.wr_done !== 1'b0 || bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_done_pulse slot%0d got done=%0b ready=%0b want 0 1", s, bus.wr_done, bus.wr_ready);
        end
    endtask

    task automatic rd(input int s, input int r, input int c,
                      output logic [XW-1:0] d, output logic e, output int lat);
        bus.rd_en       = 1'b1;
        bus.rd_slot_idx = SW'(s);
        bus.rd_row_idx  = DW'(r);
        bus.rd_col_idx  = DW'(c);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (bus.rd_elem_valid !== 1'b1 && lat < 10);
        d = bus.rd_elem;
        e = bus.rd_err;
        bus.rd_en = 1'b0;
        tick();
        checks++;
        if (bus.rd_elem_valid !== 1'b0 || bus.rd_elem !== d) begin
            errors++;
            $display("FAIL rd_pulse_hold got valid=%0b elem=%0h want 0 %0h", bus.rd_elem_valid, bus.rd_elem, d);
        end
        tick();
    endtask

    task automatic expect_rd(input string nm, input int s, input int r, input int c,
                             input logic [XW-1:0] wd, input logic we);
        logic [XW-1:0] d;
        logic          e;
        int            lat;
        rd(s, r, c, d, e, lat);
        checks++;
        if (d !== wd || e !== we || lat !== 1) begin
            errors++;
            $display("FAIL %s got elem=%0d err=%0b lat=%0d want %0d %0b 1", nm, d, e, lat, wd, we);
        end
    endtask

    task automatic test_reset;
        tick();
        checks++;
        if (bus.wr_ready !== 1'b1 || bus.wr_busy !== 1'b0 || bus.wr_done !== 1'b0 || bus.wr_err !== 1'b0 ||
            bus.rd_elem !== '0 || bus.rd_elem_valid !== 1'b0 || bus.rd_err !== 1'b0 ||
            bus.slot_valid !== '0 || bus.slot_m_flat !== '0 || bus.slot_n_flat !== '0) begin
            errors++;
            $display("FAIL reset_state got ready=%0b busy=%0b valid=%b m=%h n=%h elem=%h want 1 0 00 0 0 0",
                     bus.wr_ready, bus.wr_busy, bus.slot_valid, bus.slot_m_flat, bus.slot_n_flat, bus.rd_elem);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.wr_ready !== 1'b1 || bus.slot_valid !== '0) begin
            errors++;
            $display("FAIL reset_release got ready=%0b slot_valid=%b want 1 00", bus.wr_ready, bus.slot_valid);
        end
    endtask

    task automatic test_unloaded_read;
        expect_rd("rd_unloaded_slot1", 1, 0, 0, 8'd0, 1'b1);
    endtask

    task automatic test_load_read;
        wr_begin(0, 2, 3);
        wr_push(1, 1, 6);
        wr_finish(0, 2, 3);
        expect_rd("rd_s0_r1c2", 0, 1, 2, 8'd6, 1'b0);
        expect_rd("rd_s0_r0c0", 0, 0, 0, 8'd1, 1'b0);
        expect_rd("rd_s0_row_oob", 0, 2, 0, 8'd0, 1'b1);
        expect_rd("rd_s0_col_oob", 0, 0, 3, 8'd0, 1'b1);
    endtask

    task automatic test_bad_dims;
        int bad_m [2] = '{0, 2};
        int bad_n [2] = '{2, 6};
        for (int i = 0; i < 2; i++) begin
            bus.wr_start    = 1'b1;
            bus.wr_slot_idx = 1'b0;
            bus.wr_m        = DW'(bad_m[i]);
            bus.wr_n        = DW'(bad_n[i]);
            tick();
            bus.wr_start = 1'b0;
            checks++;
            if (bus.wr_err !== 1'b1 || bus.wr_ready !== 1'b1 || bus.slot_valid !== 2'b01) begin
                errors++;
                $display("FAIL bad_dims_%0d got err=%0b ready=%0b valid=%b want 1 1 01",
                         i, bus.wr_err, bus.wr_ready, bus.slot_valid);
            end
            tick();
            checks++;
            if (bus.wr_err !== 1'b0 || bus.wr_busy !== 1'b0) begin
                errors++;
                $display("FAIL bad_dims_pulse_%0d got err=%0b busy=%0b want 0 0", i, bus.wr_err, bus.wr_busy);
            end
        end
        expect_rd("rd_after_bad_dims", 0, 1, 1, 8'd5, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [XW-1:0] a_exp [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
        logic [XW-1:0] b_exp [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        logic [XW-1:0] s_exp [4] = '{8'd11, 8'd22, 8'd33, 8'd44};
        logic [XW-1:0] a_val, exp_v, sum;
        int nresp, nsum, last_cyc, e;
        wr_begin(0, 2, 2);
        wr_push(1, 1, 4);
        wr_finish(0, 2, 2);
        wr_begin(1, 2, 2);
        wr_push(10, 10, 4);
        wr_finish(1, 2, 2);
        nresp = 0; nsum = 0; last_cyc = -1; a_val = '0;
        bus.rd_en = 1'b1; bus.rd_slot_idx = 1'b0; bus.rd_row_idx = '0; bus.rd_col_idx = '0;
        for (int cyc = 0; cyc < 40 && nresp < 8; cyc++) begin
            tick();
            if (bus.rd_elem_valid === 1'b1) begin
                exp_v = (nresp % 2 == 0) ? a_exp[nresp/2] : b_exp[nresp/2];
                checks++;
                if (bus.rd_elem !== exp_v || bus.rd_err !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_resp%0d got elem=%0d err=%0b want %0d 0", nresp, bus.rd_elem, bus.rd_err, exp_v);
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (cyc - last_cyc !== RL + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing%0d got %0d want %0d", nresp, cyc - last_cyc, RL + 2);
                    end
                end
                last_cyc = cyc;
                if (nresp % 2 == 0) begin
                    a_val = bus.rd_elem;
                end else begin
                    sum = a_val + bus.rd_elem;
                    checks++;
                    if (sum !== s_exp[nsum]) begin
                        errors++;
                        $display("FAIL b2b_sum%0d got %0d want %0d", nsum, sum, s_exp[nsum]);
                    end
                    nsum++;
                end
                nresp++;
                e = nresp / 2;
                bus.rd_slot_idx = SW'(nresp % 2);
                bus.rd_row_idx  = DW'(e / 2);
                bus.rd_col_idx  = DW'(e % 2);
            end
        end
        bus.rd_en = 1'b0;
        checks++;
        if (nresp !== 8 || nsum !== 4) begin
            errors++;
            $display("FAIL b2b_count got resp=%0d sums=%0d want 8 4", nresp, nsum);
        end
        tick();
        tick();
    endtask

    task automatic test_reload_while_reading;
        bus.wr_start = 1'b1; bus.wr_slot_idx = 1'b0; bus.wr_m = 3'd2; bus.wr_n = 3'd2;
        bus.rd_en = 1'b1; bus.rd_slot_idx = 1'b0; bus.rd_row_idx = 3'd1; bus.rd_col_idx = 3'd1;
        tick();
        bus.wr_start = 1'b0;
        bus.rd_en    = 1'b0;
        checks++;
        if (bus.rd_elem_valid !== 1'b1 || bus.rd_elem !== 8'd4 || bus.rd_err !== 1'b0 ||
            bus.wr_busy !== 1'b1 || bus.slot_valid !== 2'b10) begin
            errors++;
            $display("FAIL same_cycle_start_read got v=%0b elem=%0d err=%0b busy=%0b sv=%b want 1 4 0 1 10",
                     bus.rd_elem_valid, bus.rd_elem, bus.rd_err, bus.wr_busy, bus.slot_valid);
        end
        tick();
        tick();
        expect_rd("reload_rd_slot1", 1, 1, 1, 8'd40, 1'b0);
        expect_rd("reload_rd_slot0_busy", 0, 0, 0, 8'd0, 1'b1);
        wr_push(5, 1, 4);
        wr_finish(0, 2, 2);
        expect_rd("reload_rd_slot0_new", 0, 1, 0, 8'd7, 1'b0);
        expect_rd("reload_rd_slot1_after", 1, 0, 1, 8'd20, 1'b0);
    endtask

    task automatic test_reset_midway;
        int vseen;
        wr_begin(1, 2, 2);
        wr_push(50, 1, 2);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.wr_busy !== 1'b0 || bus.slot_valid !== '0) begin
            errors++;
            $display("FAIL rst_fill got busy=%0b sv=%b want 0 00", bus.wr_busy, bus.slot_valid);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.wr_ready !== 1'b1 || bus.wr_done !== 1'b0 || bus.slot_valid !== '0) begin
            errors++;
            $display("FAIL rst_fill_release got ready=%0b done=%0b sv=%b want 1 0 00",
                     bus.wr_ready, bus.wr_done, bus.slot_valid);
        end
        wr_begin(0, 1, 1);
        wr_push(99, 0, 1);
        wr_finish(0, 1, 1);
        bus.rd_en = 1'b1; bus.rd_slot_idx = 1'b0; bus.rd_row_idx = '0; bus.rd_col_idx = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.rd_en = 1'b0;
        #1;
        vseen = (bus.rd_elem_valid === 1'b1) ? 1 : 0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.rd_elem_valid === 1'b1) vseen++;
        end
        checks++;
        if (vseen !== 0 || bus.wr_ready !== 1'b1 || bus.slot_valid !== '0 || bus.rd_elem !== '0) begin
            errors++;
            $display("FAIL rst_wait got valid_seen=%0d ready=%0b sv=%b elem=%0d want 0 1 00 0",
                     vseen, bus.wr_ready, bus.slot_valid, bus.rd_elem);
        end
        expect_rd("rd_after_reset", 0, 0, 0, 8'd0, 1'b1);
    endtask

    initial begin
        bus.wr_start = 1'b0; bus.wr_slot_idx = '0; bus.wr_m = '0; bus.wr_n = '0;
        bus.wr_valid = 1'b0; bus.wr_elem = '0;
        bus.rd_en = 1'b0; bus.rd_slot_idx = '0; bus.rd_row_idx = '0; bus.rd_col_idx = '0;
        test_reset();
        test_unloaded_read();
        test_load_read();
        test_bad_dims();
        test_back_to_back();
        test_reload_while_reading();
        test_reset_midway();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
